aes_core_sched: RTL and testbench
=================================

# aes_core_sched

Job scheduler and handshake sequencer sitting in front of the AES_ENC and AES_DEC cores. It accepts encrypt/decrypt jobs from two requesters, arbitrates round-robin, and drives each core's Key/Krdy/Din/Drdy/EN protocol. It caches the last key loaded into each core so the key phase is skipped on a hit, and returns Dout to the owning requester over a valid/ready channel. A watchdog converts a missing Dvld into an error response.

## Interface
- TIMEOUT, 31: maximum cycles spent in WAIT before an error response.
- CLK  in  1  clock; all state on posedge.
- RSTn  in  1  asynchronous, active-low reset.
- req_valid  in  2  job request, one bit per requester i.
- req_ready  out  2  job accepted when req_valid[i]&req_ready[i].
- req_dec  in  2  per requester: 0 = encrypt, 1 = decrypt.
- req_key  in  256  requester i key at [128*i+:128]; decrypt jobs supply the final round key.
- req_din  in  256  requester i data block at [128*i+:128].
- resp_valid  out  2  result valid for requester i.
- resp_ready  in  2  result consumed.
- resp_dout  out  128  result block, shared by both requesters.
- resp_err  out  1  1 = timeout; resp_dout is 0.
- Key, Din  out  128 each  to both cores.
- Krdy, Drdy  out  1 each  one-cycle strobes to both cores.
- EN_E, EN_D  out  1 each  core enables.
- BSY_E, BSY_D, Dvld_E, Dvld_D  in  1 each  core status.
- Dout_E, Dout_D  in  128 each  core results.

## Operation
- States: IDLE, KEY, DATA, WAIT, RESP.
- IDLE: round-robin grant g over asserted req_valid bits; req_ready[g]=1 for the granted requester only, combinationally. On accept, latch dec, key, din and owner, then go to KEY on a key-cache miss or DATA on a hit. The RR pointer moves to the other requester on each accept; after reset, requester 0 has priority.
- EN of the selected core (EN_E if dec=0, else EN_D) is 1 from the cycle after accept through the last WAIT cycle; otherwise 0. Both ENs are never 1 together.
- KEY: when the selected BSY=0, drive Key=latched key and Krdy=1 for exactly one cycle, write the cache (key, valid) for that core, then go to DATA. While BSY=1, stall with Krdy=0.
- DATA: when the selected BSY=0, drive Din and Drdy=1 for exactly one cycle, then go to WAIT. Stall the same way as KEY.
- WAIT: on the selected Dvld=1, capture the selected Dout into resp_dout with err=0, then go to RESP. The watchdog counts WAIT cycles; when it reaches TIMEOUT without Dvld, set resp_dout=0 and err=1, clear that core's cache valid, then go to RESP. If Dvld and timeout coincide, Dvld wins.
- RESP: resp_valid[owner]=1; resp_dout and resp_err are held stable. On resp_ready[owner], go to IDLE. resp_ready of the non-owner is ignored.
- Key and Din hold their last values outside the strobe cycles.
- Caches: one per core (128-bit key plus valid). A hit requires valid=1 and a full 128-bit compare.

## Timing
- Reset values: all outputs 0 (req_ready, resp_valid, resp_dout, resp_err, Key, Din, Krdy, Drdy, EN_E, EN_D). State = IDLE, caches invalid, RR pointer = 0, watchdog = 0.
- Reset asserted mid-job abandons the job immediately with no response.
- Miss, with accept at cycle 0: EN at 1, Krdy at 1, Drdy at 2, WAIT from 3. resp_valid rises the cycle after Dvld.
- Hit: Drdy at 1; one cycle shorter than a miss.
- Back-to-back: a new accept is possible in the cycle after resp_ready.

## Structure
- Shared include aes_core_sched_defs.vh holds:
  - state encodings;
  - MODE_ENC/MODE_DEC;
  - the TIMEOUT default.
- Sub-module aes_core_sched_rr_arb: 2-way round-robin grant with pointer update on accept.

## Test plan
- Encrypt, miss: key 000102030405060708090a0b0c0d0e0f, din 00112233445566778899aabbccddeeff -> one Krdy, one Drdy, resp_dout 69c4e0d86a7b0430d8cdb78070b4c55a, err 0.
- Decrypt: key 13111d7fe3944a17f307a78b4d2b30c5, din 69c4e0d8... -> EN_D only, resp_dout 00112233445566778899aabbccddeeff.
- Repeat the encrypt with the same key -> no Krdy pulse, Drdy one cycle after accept, same result.
- Both requesters valid continuously -> grants alternate 0,1,0,1; each resp_valid goes only to its owner.
- Core stubbed to never assert Dvld -> after TIMEOUT WAIT cycles, err 1, dout 0; the next job with the same key reloads it (Krdy pulses).
- RSTn pulled low during WAIT -> all outputs 0 at once; after release, the first job is a key miss.

Source files
------------

// File: rtl/aes_core_sched_pkg.sv
// Shared types, state encodings and constants for the AES core job scheduler.
package aes_core_sched_pkg;

    localparam int unsigned BLK_W       = 128;
    localparam int unsigned N_REQ       = 2;
    localparam int unsigned BUS_W       = BLK_W * N_REQ;
    localparam int unsigned TIMEOUT_DEF = 31;

    // Job direction, also selects the target core
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_DATA = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Accepted job, held for the whole handshake sequence
    typedef struct packed {
        logic             dec;
        logic             owner;
        logic [BLK_W-1:0] key;
        logic [BLK_W-1:0] din;
    } job_t;

    // Last key loaded into one core
    typedef struct packed {
        logic             valid;
        logic [BLK_W-1:0] key;
    } kcache_t;

    // Pick requester idx's 128-bit slot out of a packed two-requester bus
    function automatic logic [BLK_W-1:0] req_slot(input logic [BUS_W-1:0] bus,
                                                  input logic             idx);
        return idx ? bus[BUS_W-1:BLK_W] : bus[BLK_W-1:0];
    endfunction

endpackage

// File: rtl/aes_core_sched_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves past the winner on accept.
module aes_core_sched_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic       o_gnt_c,
    output logic       o_any_c
);

    logic r_ptr;

    // Grant the pointed-to requester when it asks, otherwise the other one
    always_comb begin
        o_any_c = |i_valid;
        o_gnt_c = i_valid[r_ptr] ? r_ptr : ~r_ptr;
    end

    // After an accept the other requester gets priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~o_gnt_c;
        end
    end

endmodule

// File: rtl/aes_core_sched.sv
// Job scheduler and Key/Krdy/Din/Drdy/EN sequencer for the AES_ENC/AES_DEC cores.
module aes_core_sched
    import aes_core_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_dec,
    input  logic [BUS_W-1:0] req_key,
    input  logic [BUS_W-1:0] req_din,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [BLK_W-1:0] resp_dout,
    output logic             resp_err,
    output logic [BLK_W-1:0] Key,
    output logic [BLK_W-1:0] Din,
    output logic             Krdy,
    output logic             Drdy,
    output logic             EN_E,
    output logic             EN_D,
    input  logic             BSY_E,
    input  logic             BSY_D,
    input  logic             Dvld_E,
    input  logic             Dvld_D,
    input  logic [BLK_W-1:0] Dout_E,
    input  logic [BLK_W-1:0] Dout_D
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    job_t             r_job;
    kcache_t          r_cache_e;
    kcache_t          r_cache_d;
    logic [WD_W-1:0]  r_wd;
    logic             r_en_e;
    logic             r_en_d;
    logic [BLK_W-1:0] r_key_q;
    logic [BLK_W-1:0] r_din_q;
    logic [1:0]       r_resp_valid;
    logic [BLK_W-1:0] r_resp_dout;
    logic             r_resp_err;

    logic             w_gnt;
    logic             w_any;
    logic             w_accept;
    logic [1:0]       w_req_ready;
    logic             w_in_dec;
    logic [BLK_W-1:0] w_in_key;
    logic [BLK_W-1:0] w_in_din;
    logic             w_in_hit;
    logic             w_bsy_sel;
    logic             w_dvld_sel;
    logic [BLK_W-1:0] w_dout_sel;
    logic             w_wd_last;
    logic             w_krdy;
    logic             w_drdy;
    logic             w_capture;
    logic             w_timeout;
    logic             w_resp_done;
    logic [1:0]       w_owner_oh;

    aes_core_sched_rr_arb u_arb (
        .clk      (CLK),
        .rst_n    (RSTn),
        .i_valid  (req_valid),
        .i_accept (w_accept),
        .o_gnt_c  (w_gnt),
        .o_any_c  (w_any)
    );

    // Granted request fields and key-cache lookup against the target core
    always_comb begin
        w_in_dec = req_dec[w_gnt];
        w_in_key = req_slot(req_key, w_gnt);
        w_in_din = req_slot(req_din, w_gnt);
        if (w_in_dec == MODE_DEC) begin
            w_in_hit = r_cache_d.valid && (r_cache_d.key == w_in_key);
        end else begin
            w_in_hit = r_cache_e.valid && (r_cache_e.key == w_in_key);
        end
    end

    // Status of the core owning the current job
    always_comb begin
        w_bsy_sel  = (r_job.dec == MODE_DEC) ? BSY_D  : BSY_E;
        w_dvld_sel = (r_job.dec == MODE_DEC) ? Dvld_D : Dvld_E;
        w_dout_sel = (r_job.dec == MODE_DEC) ? Dout_D : Dout_E;
        w_wd_last  = (r_wd == WD_W'(TIMEOUT - 1));
        w_owner_oh = r_job.owner ? 2'b10 : 2'b01;
    end

    // Next-state and per-cycle strobes
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        w_accept    = 1'b0;
        w_krdy      = 1'b0;
        w_drdy      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_req_ready = w_gnt ? 2'b10 : 2'b01;
                    w_accept    = 1'b1;
                    w_state_nxt = w_in_hit ? ST_DATA : ST_KEY;
                end
            end
            ST_KEY: begin
                if (!w_bsy_sel) begin
                    w_krdy      = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!w_bsy_sel) begin
                    w_drdy      = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result arriving on the last watchdog cycle still counts
                if (w_dvld_sel) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_wd_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready[r_job.owner]) begin
                    w_resp_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the accepted job
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_job <= '0;
        end else if (w_accept) begin
            r_job <= '{dec: w_in_dec, owner: w_gnt, key: w_in_key, din: w_in_din};
        end
    end

    // Core enable: from the cycle after accept through the last WAIT cycle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_en_e <= 1'b0;
            r_en_d <= 1'b0;
        end else if (w_accept) begin
            r_en_e <= (w_in_dec == MODE_ENC);
            r_en_d <= (w_in_dec == MODE_DEC);
        end else if (w_capture || w_timeout) begin
            r_en_e <= 1'b0;
            r_en_d <= 1'b0;
        end
    end

    // Hold the last strobed Key/Din values between strobes
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_key_q <= '0;
            r_din_q <= '0;
        end else begin
            if (w_krdy) begin
                r_key_q <= r_job.key;
            end
            if (w_drdy) begin
                r_din_q <= r_job.din;
            end
        end
    end

    // Per-core key cache: fill on key load, drop on a timed-out job
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cache_e <= '0;
            r_cache_d <= '0;
        end else if (w_krdy) begin
            if (r_job.dec == MODE_DEC) begin
                r_cache_d <= '{valid: 1'b1, key: r_job.key};
            end else begin
                r_cache_e <= '{valid: 1'b1, key: r_job.key};
            end
        end else if (w_timeout) begin
            if (r_job.dec == MODE_DEC) begin
                r_cache_d.valid <= 1'b0;
            end else begin
                r_cache_e.valid <= 1'b0;
            end
        end
    end

    // Watchdog counts consecutive WAIT cycles without a result
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wd <= '0;
        end else if ((r_state == ST_WAIT) && !w_capture && !w_timeout) begin
            r_wd <= r_wd + WD_W'(1);
        end else begin
            r_wd <= '0;
        end
    end

    // Response channel: result or error held until the owner consumes it
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_resp_valid <= 2'b00;
            r_resp_dout  <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_capture) begin
            r_resp_valid <= w_owner_oh;
            r_resp_dout  <= w_dout_sel;
            r_resp_err   <= 1'b0;
        end else if (w_timeout) begin
            r_resp_valid <= w_owner_oh;
            r_resp_dout  <= '0;
            r_resp_err   <= 1'b1;
        end else if (w_resp_done) begin
            r_resp_valid <= 2'b00;
        end
    end

    // Output drive; strobes and ready are combinational, the rest registered
    always_comb begin
        req_ready  = w_req_ready;
        Krdy       = w_krdy;
        Drdy       = w_drdy;
        Key        = w_krdy ? r_job.key : r_key_q;
        Din        = w_drdy ? r_job.din : r_din_q;
        EN_E       = r_en_e;
        EN_D       = r_en_d;
        resp_valid = r_resp_valid;
        resp_dout  = r_resp_dout;
        resp_err   = r_resp_err;
    end

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench for aes_core_sched with behavioural AES core stubs.
module tb_aes_core_sched;

    localparam logic [127:0] K_E = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_D = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2  = 128'hfedcba9876543210f0e1d2c3b4a59687;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] XD  = 128'h0123456789abcdef0f1e2d3c4b5a6978;
    localparam logic [127:0] GARB = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         CLK;
    logic         RSTn;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_dec;
    logic [255:0] req_key;
    logic [255:0] req_din;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [127:0] resp_dout;
    logic         resp_err;
    logic [127:0] Key;
    logic [127:0] Din;
    logic         Krdy;
    logic         Drdy;
    logic         EN_E;
    logic         EN_D;
    logic         BSY_E;
    logic         BSY_D;
    logic         Dvld_E;
    logic         Dvld_D;
    logic [127:0] Dout_E;
    logic [127:0] Dout_D;

    aes_core_sched dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dec    (req_dec),
        .req_key    (req_key),
        .req_din    (req_din),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_dout  (resp_dout),
        .resp_err   (resp_err),
        .Key        (Key),
        .Din        (Din),
        .Krdy       (Krdy),
        .Drdy       (Drdy),
        .EN_E       (EN_E),
        .EN_D       (EN_D),
        .BSY_E      (BSY_E),
        .BSY_D      (BSY_D),
        .Dvld_E     (Dvld_E),
        .Dvld_D     (Dvld_D),
        .Dout_E     (Dout_E),
        .Dout_D     (Dout_D)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // monitor counters (written only by the monitor)
    int n_krdy = 0;
    int n_drdy = 0;
    int n_en_e = 0;
    int n_en_d = 0;
    int n_both = 0;
    int krdy_cyc = -1;
    int drdy_cyc = -1;

    // stub control
    int stub_lat = 1;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Stand-in for the AES cores: known vector pair, else a simple keyed mix
    function automatic logic [127:0] core_model(input logic dec, input logic [127:0] k,
                                                input logic [127:0] d);
        if (!dec) return (k == K_E && d == PT) ? CT : (d ^ k);
        return (k == K_D && d == CT) ? PT : (d ^ ~k);
    endfunction

    // Monitor sampling DUT outputs mid-cycle
    initial begin
        forever begin
            @(negedge CLK);
            if (RSTn) begin
                if (Krdy) begin n_krdy++; krdy_cyc = cyc; end
                if (Drdy) begin n_drdy++; drdy_cyc = cyc; end
                if (EN_E) n_en_e++;
                if (EN_D) n_en_d++;
                if (EN_E && EN_D) n_both++;
            end
        end
    end

    // Core stubs: hold the loaded key, answer stub_lat cycles after Drdy (0 = never)
    initial begin
        logic [127:0] ck_e, ck_d, s_key, s_din, p_din;
        logic s_k, s_d, s_en_e, s_en_d, p_dec, pend;
        int cnt;
        ck_e = '0; ck_d = '0; pend = 1'b0; p_dec = 1'b0; p_din = '0; cnt = 0;
        Dvld_E = 1'b0; Dvld_D = 1'b0; Dout_E = GARB; Dout_D = GARB;
        forever begin
            @(negedge CLK);
            s_k = Krdy; s_d = Drdy; s_en_e = EN_E; s_en_d = EN_D;
            s_key = Key; s_din = Din;
            @(posedge CLK);
            #1;
            Dvld_E = 1'b0; Dvld_D = 1'b0; Dout_E = GARB; Dout_D = GARB;
            if (!RSTn) begin
                pend = 1'b0;
            end else begin
                if (s_k && s_en_e) ck_e = s_key;
                if (s_k && s_en_d) ck_d = s_key;
                if (s_d && stub_lat != 0) begin
                    pend = 1'b1; p_dec = s_en_d; p_din = s_din; cnt = stub_lat;
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 1'b0;
                        if (p_dec) begin
                            Dvld_D = 1'b1; Dout_D = core_model(1'b1, ck_d, p_din);
                        end else begin
                            Dvld_E = 1'b1; Dout_E = core_model(1'b0, ck_e, p_din);
                        end
                    end
                end
            end
        end
    end

    typedef struct {
        int           r;
        logic         dec;
        logic [127:0] key;
        logic [127:0] din;
        int           miss;
        int           lat;
        int           stall;
        logic [127:0] dout;
        logic         err;
    } vec_t;

    // Run one job from a single requester and check its whole handshake
    task automatic do_job(input vec_t v, input string nm);
        int acc, rc, k0, d0, ee0, ed0, first, exp_rc, en_sel, en_oth;
        logic [1:0] oh;
        k0 = n_krdy; d0 = n_drdy; ee0 = n_en_e; ed0 = n_en_d;
        oh = (v.r == 1) ? 2'b10 : 2'b01;
        @(posedge CLK); #1;
        stub_lat = v.lat;
        req_valid[v.r] = 1'b1;
        req_dec[v.r] = v.dec;
        req_key[128*v.r +: 128] = v.key;
        req_din[128*v.r +: 128] = v.din;
        acc = -1;
        for (int t = 0; t < 50 && acc < 0; t++) begin
            @(negedge CLK);
            if (req_ready[v.r]) begin
                acc = cyc;
                chk({nm, "_ready_onehot"}, 128'(req_ready), 128'(oh));
            end
        end
        chk({nm, "_accept"}, 128'(acc >= 0), 128'(1));
        if (acc < 0) begin
            req_valid = 2'b00;
            return;
        end
        @(posedge CLK); #1;
        req_valid[v.r] = 1'b0;
        if (v.stall > 0) begin
            if (v.dec) BSY_D = 1'b1; else BSY_E = 1'b1;
            repeat (v.stall) @(posedge CLK);
            #1;
            BSY_D = 1'b0; BSY_E = 1'b0;
        end
        rc = -1;
        for (int t = 0; t < 100 && rc < 0; t++) begin
            @(negedge CLK);
            if (resp_valid != 2'b00) rc = cyc;
        end
        chk({nm, "_resp_seen"}, 128'(rc >= 0), 128'(1));
        if (rc < 0) return;
        first = acc + 1 + v.stall;
        chk({nm, "_krdy_cnt"}, 128'(n_krdy - k0), 128'(v.miss));
        if (v.miss != 0) chk({nm, "_krdy_cyc"}, 128'(krdy_cyc), 128'(first));
        chk({nm, "_drdy_cnt"}, 128'(n_drdy - d0), 128'(1));
        chk({nm, "_drdy_cyc"}, 128'(drdy_cyc), 128'(first + v.miss));
        exp_rc = (v.lat == 0) ? (first + v.miss + 32) : (first + v.miss + v.lat + 1);
        chk({nm, "_resp_cyc"}, 128'(rc), 128'(exp_rc));
        chk({nm, "_resp_valid"}, 128'(resp_valid), 128'(oh));
        chk({nm, "_dout"}, resp_dout, v.dout);
        chk({nm, "_err"}, 128'(resp_err), 128'(v.err));
        en_sel = v.dec ? (n_en_d - ed0) : (n_en_e - ee0);
        en_oth = v.dec ? (n_en_e - ee0) : (n_en_d - ed0);
        chk({nm, "_en_cycles"}, 128'(en_sel), 128'(rc - 1 - acc));
        chk({nm, "_en_other"}, 128'(en_oth), 128'(0));
        // non-owner ready must not retire the response
        @(posedge CLK); #1;
        resp_ready[1 - v.r] = 1'b1;
        @(posedge CLK); #1;
        resp_ready = 2'b00;
        resp_ready[v.r] = 1'b1;
        chk({nm, "_hold_valid"}, 128'(resp_valid), 128'(oh));
        chk({nm, "_hold_dout"}, resp_dout, v.dout);
        @(posedge CLK); #1;
        resp_ready = 2'b00;
        @(negedge CLK);
        chk({nm, "_retired"}, 128'(resp_valid), 128'(0));
    endtask

    vec_t vecs[10];

    initial begin
        int acc, rc, prev_rc, idx, d0;
        vec_t v;
        vecs[0] = '{0, 1'b0, K_E, PT, 1, 3, 0, CT, 1'b0};
        vecs[1] = '{1, 1'b1, K_D, CT, 1, 2, 0, PT, 1'b0};
        vecs[2] = '{0, 1'b0, K_E, PT, 0, 1, 0, CT, 1'b0};
        vecs[3] = '{1, 1'b1, K_D, CT, 0, 4, 2, PT, 1'b0};
        vecs[4] = '{1, 1'b0, K_E, XD, 0, 2, 0, XD ^ K_E, 1'b0};
        vecs[5] = '{0, 1'b0, K2,  PT, 1, 3, 1, PT ^ K2, 1'b0};
        vecs[6] = '{0, 1'b0, K_E, PT, 1, 31, 0, CT, 1'b0};
        vecs[7] = '{0, 1'b0, K_E, PT, 0, 0, 0, 128'h0, 1'b1};
        vecs[8] = '{1, 1'b0, K_E, PT, 1, 2, 0, CT, 1'b0};
        vecs[9] = '{0, 1'b1, K_D, CT, 0, 1, 0, PT, 1'b0};

        RSTn = 1'b0; req_valid = '0; req_dec = '0; req_key = '0; req_din = '0;
        resp_ready = '0; BSY_E = 1'b0; BSY_D = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_resp", {resp_valid, resp_err, resp_dout}, 128'h0);
        chk("rst_strobes", 128'({req_ready, Krdy, Drdy, EN_E, EN_D}), 128'h0);
        chk("rst_key_din", Key | Din, 128'h0);
        RSTn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_job(vecs[i], $sformatf("v%0d", i));
        end

        // reset in the middle of a WAIT phase
        @(posedge CLK); #1;
        stub_lat = 0;
        req_valid[0] = 1'b1; req_dec[0] = 1'b0; req_key[127:0] = K_E; req_din[127:0] = PT;
        d0 = n_drdy; acc = -1;
        for (int t = 0; t < 50 && acc < 0; t++) begin
            @(negedge CLK);
            if (req_ready[0]) acc = cyc;
        end
        chk("rstjob_accept", 128'(acc >= 0), 128'(1));
        @(posedge CLK); #1;
        req_valid = 2'b00;
        for (int t = 0; t < 20 && n_drdy == d0; t++) @(negedge CLK);
        chk("rstjob_drdy", 128'(n_drdy - d0), 128'(1));
        repeat (3) @(posedge CLK);
        #1;
        chk("rstjob_en_before", 128'(EN_E), 128'(1));
        RSTn = 1'b0;
        #1;
        chk("rstmid_resp", {resp_valid, resp_err, resp_dout}, 128'h0);
        chk("rstmid_strobes", 128'({req_ready, Krdy, Drdy, EN_E, EN_D}), 128'h0);
        chk("rstmid_key_din", Key | Din, 128'h0);
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        v = '{1, 1'b0, K_E, PT, 1, 2, 0, CT, 1'b0};
        do_job(v, "post_rst");

        // both requesters continuously valid: grants alternate, back-to-back accepts
        @(posedge CLK); #1;
        stub_lat = 2;
        resp_ready = 2'b11;
        req_dec = 2'b00;
        req_key = {K_E, K_E};
        req_din = {XD, PT};
        req_valid = 2'b11;
        prev_rc = -1;
        for (int k = 0; k < 4; k++) begin
            acc = -1; idx = 0;
            for (int t = 0; t < 50 && acc < 0; t++) begin
                @(negedge CLK);
                if ((req_valid & req_ready) != 2'b00) begin
                    acc = cyc;
                    idx = req_ready[1] ? 1 : 0;
                end
            end
            chk($sformatf("rr%0d_accept", k), 128'(acc >= 0), 128'(1));
            chk($sformatf("rr%0d_grant", k), 128'(idx), 128'(k % 2));
            if (prev_rc >= 0) chk($sformatf("rr%0d_b2b", k), 128'(acc), 128'(prev_rc + 1));
            rc = -1;
            for (int t = 0; t < 50 && rc < 0; t++) begin
                @(negedge CLK);
                if (resp_valid != 2'b00) rc = cyc;
            end
            if (k == 3) req_valid = 2'b00;
            chk($sformatf("rr%0d_owner", k), 128'(resp_valid), 128'((idx == 1) ? 2'b10 : 2'b01));
            chk($sformatf("rr%0d_dout", k), resp_dout, (idx == 1) ? (XD ^ K_E) : CT);
            prev_rc = rc;
        end
        @(posedge CLK); #1;
        resp_ready = 2'b00;
        repeat (2) @(posedge CLK);
        chk("never_both_en", 128'(n_both), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
